// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller arbitrating instruction fetch and the
// load/store buffer onto one 8-bit RAM/IO port; assembles and extends read data.
// Ports: clk/rst/rdy/clear control; if_* fetch port; lsb_* load/store port;
//        mem_* byte bus to RAM/IO; io_buffer_full IO back-pressure input.
// Latency: N-byte read done in cycle N+2 after grant, N-byte write in cycle N+1.
// Backpressure: rdy low freezes every register; IO writes wait in IOWAIT while full.
module mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clear,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        lsb_req,
   input  logic        lsb_we,
   input  logic [1:0]  lsb_size,
   input  logic        lsb_signed,
   input  logic [31:0] lsb_addr,
   input  logic [31:0] lsb_wdata,
   output logic        lsb_done,
   output logic [31:0] lsb_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ   = 2'd1,
      S_WRITE  = 2'd2,
      S_IOWAIT = 2'd3
   } state_t;

   localparam logic OWN_IF  = 1'b0;
   localparam logic OWN_LSB = 1'b1;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  len_q, len_d;
   logic [31:0] base_q, base_d;
   logic        owner_q, owner_d;
   logic        last_grant_q, last_grant_d;
   logic        sgn_q, sgn_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] asm_q, asm_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [7:0]  mem_dout_q, mem_dout_d;
   logic        wr_q, wr_d;
   logic        if_done_q, if_done_d;
   logic [31:0] if_data_q, if_data_d;
   logic        lsb_done_q, lsb_done_d;
   logic [31:0] lsb_rdata_q, lsb_rdata_d;

   // grant candidate operands
   logic        if_ok, lsb_ok, pick_lsb;
   logic [31:0] g_addr, g_wdata;
   logic [2:0]  g_len;
   logic [1:0]  g_size;
   logic        g_we, g_sgn;

   logic [2:0]  cnt_nx;
   logic [2:0]  cap_idx;
   logic [31:0] asm_ins;

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
      logic [7:0] r;
      r = w[7:0];
      case (i)
         2'd0: r = w[7:0];
         2'd1: r = w[15:8];
         2'd2: r = w[23:16];
         2'd3: r = w[31:24];
         default: r = w[7:0];
      endcase
      return r;
   endfunction

   function automatic logic [31:0] byte_ins(input logic [31:0] w, input logic [1:0] i,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = w;
      case (i)
         2'd0: r[7:0]   = b;
         2'd1: r[15:8]  = b;
         2'd2: r[23:16] = b;
         2'd3: r[31:24] = b;
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                            input logic sg);
      logic [31:0] r;
      r = w;
      if (sz == 2'b00)
         r = {{24{sg & w[7]}}, w[7:0]};
      else if (sz == 2'b01)
         r = {{16{sg & w[15]}}, w[15:0]};
      return r;
   endfunction

   function automatic logic [2:0] size_len(input logic [1:0] sz);
      logic [2:0] r;
      case (sz)
         2'b00:   r = 3'd1;
         2'b01:   r = 3'd2;
         default: r = 3'd4;
      endcase
      return r;
   endfunction

   // Arbitration inputs. A requester whose done is showing is still holding
   // its old request, so it must not win again. clear kills reads only.
   always_comb begin
      if_ok    = if_req & ~if_done_q & ~clear;
      lsb_ok   = lsb_req & ~lsb_done_q & ~(clear & ~lsb_we);
      pick_lsb = lsb_ok & (~if_ok | (last_grant_q == OWN_IF));
      if (pick_lsb) begin
         g_addr  = lsb_addr;
         g_wdata = lsb_wdata;
         g_len   = size_len(lsb_size);
         g_size  = lsb_size;
         g_we    = lsb_we;
         g_sgn   = lsb_signed;
      end else begin
         g_addr  = if_addr;
         g_wdata = 32'd0;
         g_len   = 3'd4;
         g_size  = 2'b10;
         g_we    = 1'b0;
         g_sgn   = 1'b0;
      end
   end

   // In READ, cnt_q is the index of the address on the bus; the byte arriving
   // now belongs to the previous address, hence cap_idx = cnt_q - 1.
   assign cnt_nx  = cnt_q + 3'd1;
   assign cap_idx = cnt_q - 3'd1;
   assign asm_ins = byte_ins(asm_q, cap_idx[1:0], mem_din);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      base_d       = base_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      sgn_d        = sgn_q;
      size_d       = size_q;
      wdata_d      = wdata_q;
      asm_d        = asm_q;
      mem_a_d      = mem_a_q;
      mem_dout_d   = mem_dout_q;
      wr_d         = wr_q;
      if_done_d    = 1'b0;
      if_data_d    = if_data_q;
      lsb_done_d   = 1'b0;
      lsb_rdata_d  = lsb_rdata_q;

      case (state_q)
         S_IDLE: begin
            mem_a_d    = 32'd0;
            mem_dout_d = 8'd0;
            wr_d       = 1'b0;
            cnt_d      = 3'd0;
            if (if_ok | lsb_ok) begin
               owner_d      = pick_lsb;
               last_grant_d = pick_lsb;
               base_d       = g_addr;
               len_d        = g_len;
               size_d       = g_size;
               sgn_d        = g_sgn;
               wdata_d      = g_wdata;
               asm_d        = 32'd0;
               if (!g_we) begin
                  state_d = S_READ;
                  mem_a_d = g_addr;
               end else if ((g_addr[17:16] == 2'b11) && io_buffer_full) begin
                  state_d = S_IOWAIT;
               end else begin
                  state_d    = S_WRITE;
                  mem_a_d    = g_addr;
                  mem_dout_d = g_wdata[7:0];
                  wr_d       = 1'b1;
               end
            end
         end

         S_READ: begin
            if (clear) begin
               state_d = S_IDLE;
               cnt_d   = 3'd0;
               mem_a_d = 32'd0;
            end else begin
               if (cnt_q != 3'd0)
                  asm_d = asm_ins;
               if (cnt_q == len_q) begin
                  // last byte captured this edge
                  state_d = S_IDLE;
                  cnt_d   = 3'd0;
                  mem_a_d = 32'd0;
                  if (owner_q == OWN_LSB) begin
                     lsb_done_d  = 1'b1;
                     lsb_rdata_d = load_ext(asm_ins, size_q, sgn_q);
                  end else begin
                     if_done_d = 1'b1;
                     if_data_d = asm_ins;
                  end
               end else begin
                  cnt_d   = cnt_nx;
                  mem_a_d = (cnt_nx < len_q) ? base_q + {29'd0, cnt_nx} : 32'd0;
               end
            end
         end

         S_WRITE: begin
            if (cnt_q == len_q - 3'd1) begin
               state_d    = S_IDLE;
               cnt_d      = 3'd0;
               mem_a_d    = 32'd0;
               mem_dout_d = 8'd0;
               wr_d       = 1'b0;
               lsb_done_d = 1'b1;
            end else begin
               cnt_d      = cnt_nx;
               mem_a_d    = base_q + {29'd0, cnt_nx};
               mem_dout_d = byte_sel(wdata_q, cnt_nx[1:0]);
               wr_d       = 1'b1;
            end
         end

         S_IOWAIT: begin
            if (!io_buffer_full) begin
               state_d    = S_WRITE;
               cnt_d      = 3'd0;
               mem_a_d    = base_q;
               mem_dout_d = wdata_q[7:0];
               wr_d       = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 3'd0;
         len_q        <= 3'd0;
         base_q       <= 32'd0;
         owner_q      <= OWN_IF;
         last_grant_q <= OWN_IF;
         sgn_q        <= 1'b0;
         size_q       <= 2'b00;
         wdata_q      <= 32'd0;
         asm_q        <= 32'd0;
         mem_a_q      <= 32'd0;
         mem_dout_q   <= 8'd0;
         wr_q         <= 1'b0;
         if_done_q    <= 1'b0;
         if_data_q    <= 32'd0;
         lsb_done_q   <= 1'b0;
         lsb_rdata_q  <= 32'd0;
      end else if (rdy) begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         base_q       <= base_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         sgn_q        <= sgn_d;
         size_q       <= size_d;
         wdata_q      <= wdata_d;
         asm_q        <= asm_d;
         mem_a_q      <= mem_a_d;
         mem_dout_q   <= mem_dout_d;
         wr_q         <= wr_d;
         if_done_q    <= if_done_d;
         if_data_q    <= if_data_d;
         lsb_done_q   <= lsb_done_d;
         lsb_rdata_q  <= lsb_rdata_d;
      end
   end

   assign if_done   = if_done_q;
   assign if_data   = if_data_q;
   assign lsb_done  = lsb_done_q;
   assign lsb_rdata = lsb_rdata_q;
   assign mem_a     = mem_a_q;
   assign mem_dout  = mem_dout_q;
   // a frozen cycle must not repeat a write (IO side effects)
   assign mem_wr    = wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vectors and multi-cycle sequences for mem_ctrl.
// Latency: cycle 0 is the cycle in which the request is first driven.
// Backpressure: bench RAM freezes with rdy, like the rest of the core.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy, clear;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        lsb_req, lsb_we, lsb_signed;
   logic [1:0]  lsb_size;
   logic [31:0] lsb_addr, lsb_wdata;
   logic        lsb_done;
   logic [31:0] lsb_rdata;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] ram  [0:4095];
   logic [7:0] wmem [0:4095];
   int         wr_cnt = 0;

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_size(lsb_size), .lsb_signed(lsb_signed),
      .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   // RAM: one-cycle read latency, frozen along with the core when rdy is low
   always @(posedge clk) begin
      if (rdy) begin
         mem_din <= ram[mem_a[11:0]];
         if (mem_wr) begin
            wmem[mem_a[11:0]] <= mem_dout;
            wr_cnt <= wr_cnt + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        lsb;
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] ram_w;   // bytes preloaded at addr.. (reads)
      int          lat;     // cycle in which done is expected
      logic [31:0] exp;     // read data, or bytes expected in memory (writes)
   } vec_t;

   vec_t vecs [11];

   task automatic idle_lines();
      if_req = 0; lsb_req = 0; lsb_we = 0; clear = 0;
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int n, done_c;
      logic [31:0] a, tmp, act;
      n = (!v.lsb) ? 4 : (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
      for (int k = 0; k < n; k++) begin
         a = v.addr + k;
         tmp = v.ram_w >> (8 * k);
         ram[a[11:0]] = tmp[7:0];
      end
      @(negedge clk);
      if (v.lsb) begin
         lsb_req = 1; lsb_we = v.we; lsb_size = v.size; lsb_signed = v.sgn;
         lsb_addr = v.addr; lsb_wdata = v.wdata;
      end else begin
         if_req = 1; if_addr = v.addr;
      end
      done_c = 0;
      for (int c = 1; c <= 20 && done_c == 0; c++) begin
         @(negedge clk);
         if (c <= n) begin
            chk($sformatf("v%0d mem_a c%0d", id, c), mem_a, v.addr + (c - 1));
            if (v.we) begin
               tmp = v.wdata >> (8 * (c - 1));
               chk($sformatf("v%0d mem_wr c%0d", id, c), {31'd0, mem_wr}, 32'd1);
               chk($sformatf("v%0d mem_dout c%0d", id, c), {24'd0, mem_dout}, {24'd0, tmp[7:0]});
            end
         end
         if (v.lsb ? lsb_done : if_done) done_c = c;
      end
      idle_lines();
      chk($sformatf("v%0d done cycle", id), done_c, v.lat);
      if (!v.we) begin
         chk($sformatf("v%0d rdata", id), v.lsb ? lsb_rdata : if_data, v.exp);
      end else begin
         chk($sformatf("v%0d mem_wr after", id), {31'd0, mem_wr}, 32'd0);
         act = 32'd0;
         for (int k = 0; k < n; k++) begin
            a = v.addr + k;
            act = act | ({24'd0, wmem[a[11:0]]} << (8 * k));
         end
         chk($sformatf("v%0d stored", id), act, v.exp);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int d_cnt, done_c, w0;
      int d_cyc [4];
      logic d_own [4];
      logic [31:0] d_dat [4];

      for (int i = 0; i < 4096; i++) begin
         ram[i] = 8'h00;
         wmem[i] = 8'h00;
      end
      rst = 1; rdy = 1; io_buffer_full = 0;
      if_addr = 0; lsb_size = 0; lsb_signed = 0; lsb_addr = 0; lsb_wdata = 0;
      idle_lines();

      //               lsb  we    sz     sgn   addr           wdata          ram_w          lat exp
      vecs[0]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0513, 6, 32'h0000_0513};
      vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0080, 3, 32'hFFFF_FF80};
      vecs[2]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_FF80, 4, 32'h0000_FF80};
      vecs[3]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_FF80, 4, 32'hFFFF_FF80};
      vecs[4]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0080, 3, 32'h0000_0080};
      vecs[5]  = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0024, 32'h0,         32'h1234_5678, 6, 32'h1234_5678};
      vecs[6]  = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         5, 32'hDEAD_BEEF};
      vecs[7]  = '{1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0050, 32'hCAFE_1234, 32'h0,         3, 32'h0000_1234};
      vecs[8]  = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0060, 32'h7777_77A5, 32'h0,         2, 32'h0000_00A5};
      vecs[9]  = '{1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_0028, 32'h0,         32'h89AB_CDEF, 6, 32'h89AB_CDEF};
      vecs[10] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0,         32'hA1B2_C3D4, 6, 32'hA1B2_C3D4};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset if_done",   {31'd0, if_done},  32'd0);
      chk("reset lsb_done",  {31'd0, lsb_done}, 32'd0);
      chk("reset mem_wr",    {31'd0, mem_wr},   32'd0);
      chk("reset mem_a",     mem_a,             32'd0);
      chk("reset mem_dout",  {24'd0, mem_dout}, 32'd0);
      chk("reset if_data",   if_data,           32'd0);
      chk("reset lsb_rdata", lsb_rdata,         32'd0);
      rst = 0;
      @(negedge clk);

      // contention straight after reset: LSB first, then alternate
      @(negedge clk);
      if_req = 1; if_addr = 32'h100;
      lsb_req = 1; lsb_we = 0; lsb_size = 2'b10; lsb_signed = 0; lsb_addr = 32'h24;
      ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
      ram[12'h024] = 8'h78; ram[12'h025] = 8'h56; ram[12'h026] = 8'h34; ram[12'h027] = 8'h12;
      d_cnt = 0;
      for (int c = 1; c <= 60 && d_cnt < 4; c++) begin
         @(negedge clk);
         if (if_done || lsb_done) begin
            d_cyc[d_cnt] = c;
            d_own[d_cnt] = lsb_done;
            d_dat[d_cnt] = lsb_done ? lsb_rdata : if_data;
            d_cnt++;
         end
      end
      idle_lines();
      chk("arb done count", d_cnt, 4);
      for (int i = 0; i < d_cnt; i++) begin
         chk($sformatf("arb owner %0d", i), {31'd0, d_own[i]}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("arb cycle %0d", i), d_cyc[i], 6 * (i + 1));
         chk($sformatf("arb data %0d", i), d_dat[i], (i % 2 == 0) ? 32'h1234_5678 : 32'h0000_0513);
      end
      repeat (2) @(negedge clk);

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // flush in cycle 3 of a fetch
      @(negedge clk);
      if_req = 1; if_addr = 32'h100;
      done_c = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (if_done) done_c++;
         if (c == 3) begin clear = 1; if_req = 0; end
         if (c == 4) begin
            clear = 0;
            chk("flush idle mem_a", mem_a, 32'd0);
         end
      end
      chk("flush no if_done", done_c, 0);

      // clear during a store: store still completes
      @(negedge clk);
      lsb_req = 1; lsb_we = 1; lsb_size = 2'b10; lsb_addr = 32'h70; lsb_wdata = 32'h1122_3344;
      done_c = 0;
      for (int c = 1; c <= 12 && done_c == 0; c++) begin
         @(negedge clk);
         clear = (c == 2);
         if (lsb_done) done_c = c;
      end
      idle_lines();
      chk("store+clear done", done_c, 5);
      chk("store+clear mem", {wmem[12'h073], wmem[12'h072], wmem[12'h071], wmem[12'h070]}, 32'h1122_3344);
      repeat (2) @(negedge clk);

      // IO byte store against a full buffer
      @(negedge clk);
      w0 = wr_cnt;
      io_buffer_full = 1;
      lsb_req = 1; lsb_we = 1; lsb_size = 2'b00; lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0000_0041;
      done_c = 0;
      for (int c = 1; c <= 15 && done_c == 0; c++) begin
         @(negedge clk);
         if (c <= 5) chk($sformatf("io wait mem_wr c%0d", c), {31'd0, mem_wr}, 32'd0);
         if (c == 5) io_buffer_full = 0;
         if (c == 6) begin
            chk("io write mem_wr", {31'd0, mem_wr}, 32'd1);
            chk("io write mem_a", mem_a, 32'h0003_0000);
         end
         if (lsb_done) done_c = c;
      end
      idle_lines();
      chk("io done cycle", done_c, 7);
      chk("io write count", wr_cnt - w0, 1);
      chk("io write byte", {24'd0, wmem[12'h000]}, 32'h41);
      repeat (2) @(negedge clk);

      // freeze for three edges in the middle of a word fetch
      @(negedge clk);
      if_req = 1; if_addr = 32'h100;
      done_c = 0;
      for (int c = 1; c <= 20 && done_c == 0; c++) begin
         @(negedge clk);
         if (c == 2) rdy = 0;
         if (c == 5) rdy = 1;
         if (if_done && rdy) done_c = c;
      end
      idle_lines();
      rdy = 1;
      chk("freeze done cycle", done_c, 9);
      chk("freeze data", if_data, 32'h0000_0513);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
